// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and per-cycle handshake status.
// Optional occupancy port fifo_level is built when FIFO_LEVEL_OUT_EN is defined.
module sync_fifo #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic                          rd_en,
   input  logic [FIFO_WIDTH-1:0]         data_in,
   output logic [FIFO_WIDTH-1:0]         data_out,
   output logic                          wr_ack,
   output logic                          overflow,
   output logic                          underflow,
   output logic                          full,
   output logic                          almostfull,
   output logic                          empty,
   output logic                          almostempty
`ifdef FIFO_LEVEL_OUT_EN
   ,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH-1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [FIFO_WIDTH-1:0] r_data_out;
   logic                  r_wr_ack, r_overflow, r_underflow;
   logic                  w_wa, w_ra;

   assign w_wa = wr_en && (r_count != DEPTH_C);
   assign w_ra = rd_en && (r_count != '0);

   // Storage is never reset; stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (!rst && w_wa) r_mem[r_wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_data_out  <= '0;
         r_wr_ack    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wa) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         if (w_ra) begin
            r_rd_ptr   <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            r_data_out <= r_mem[r_rd_ptr];
         end
         if (w_wa && !w_ra)      r_count <= r_count + 1'b1;
         else if (w_ra && !w_wa) r_count <= r_count - 1'b1;
         r_wr_ack    <= w_wa;
         r_overflow  <= wr_en && !w_wa;
         r_underflow <= rd_en && !w_ra;
      end
   end

   assign data_out    = r_data_out;
   assign wr_ack      = r_wr_ack;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
   assign full        = (r_count == DEPTH_C);
   assign almostfull  = (r_count == DEPTH_C - 1'b1);
   assign empty       = (r_count == '0);
   assign almostempty = (r_count == CW'(1));
`ifdef FIFO_LEVEL_OUT_EN
   assign fifo_level  = r_count;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (WIDTH=16, DEPTH=8); outputs checked 1ns after each edge.
module tb_sync_fifo;

   logic        clk = 1'b0;
   logic        rst, wr_en, rd_en;
   logic [15:0] data_in, data_out;
   logic        wr_ack, overflow, underflow, full, almostfull, empty, almostempty;
`ifdef FIFO_LEVEL_OUT_EN
   logic [3:0]  fifo_level;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
      .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
      .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty)
`ifdef FIFO_LEVEL_OUT_EN
      , .fifo_level(fifo_level)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Flags as one vector {full, almostfull, almostempty, empty}
   task automatic chk_flags(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, full, almostfull, almostempty, empty}, {28'd0, exp});
   endtask

   task automatic chk_stat(input string tag, input logic [2:0] exp);
      chk(tag, {29'd0, wr_ack, overflow, underflow}, {29'd0, exp});
   endtask

   task automatic chk_lvl(input string tag, input int exp);
`ifdef FIFO_LEVEL_OUT_EN
      chk(tag, {28'd0, fifo_level}, exp);
`endif
   endtask

   task automatic step(input logic r, input logic w, input logic rd, input logic [15:0] d);
      rst = r; wr_en = w; rd_en = rd; data_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 16'hFFFF;
      // Reset with requests asserted for two edges
      step(1, 1, 1, 16'hFFFF);
      step(1, 1, 1, 16'hFFFF);
      chk_flags("rst_flags", 4'b0001);
      chk("rst_dout", {16'd0, data_out}, 32'd0);
      chk_stat("rst_stat", 3'b000);
      chk_lvl("rst_lvl", 0);

      // Fill with 1..8
      for (int i = 1; i <= 8; i++) begin
         step(0, 1, 0, 16'(i));
         chk_stat($sformatf("wr%0d_stat", i), 3'b100);
         if (i == 1) chk_flags("wr1_flags", 4'b0010);
         if (i == 7) chk_flags("wr7_flags", 4'b0100);
         if (i == 8) chk_flags("wr8_flags", 4'b1000);
      end
      chk_lvl("full_lvl", 8);
      step(0, 1, 0, 16'hBEEF);
      chk_stat("ovf_stat", 3'b010);
      chk_flags("ovf_flags", 4'b1000);

      // Drain in order; overflow must not be sticky
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 1, 16'h0);
         chk($sformatf("rd%0d_dout", i), {16'd0, data_out}, 32'(i));
         chk_stat($sformatf("rd%0d_stat", i), 3'b000);
         if (i == 1) chk_flags("rd1_flags", 4'b0100);
         if (i == 7) chk_flags("rd7_flags", 4'b0010);
         if (i == 8) chk_flags("rd8_flags", 4'b0001);
      end
      step(0, 0, 1, 16'h0);
      chk_stat("udf_stat", 3'b001);
      chk("udf_dout", {16'd0, data_out}, 32'h8);
      chk_flags("udf_flags", 4'b0001);

      // Prime count=4 then stream 20 cycles of simultaneous read/write
      for (int i = 0; i < 4; i++) step(0, 1, 0, 16'(16'h10 + i));
      chk_lvl("prime_lvl", 4);
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 1, 16'(16'h14 + i));
         chk($sformatf("strm%0d_dout", i), {16'd0, data_out}, 32'(16'h10 + i));
         chk_flags($sformatf("strm%0d_flags", i), 4'b0000);
         chk_stat($sformatf("strm%0d_stat", i), 3'b100);
         chk_lvl($sformatf("strm%0d_lvl", i), 4);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 16'h0);
         chk($sformatf("tail%0d_dout", i), {16'd0, data_out}, 32'(16'h24 + i));
      end
      chk_flags("tail_flags", 4'b0001);

      // Simultaneous at empty: write only, underflow
      step(0, 1, 1, 16'h00AA);
      chk_stat("emp_rw_stat", 3'b101);
      chk_flags("emp_rw_flags", 4'b0010);
      chk("emp_rw_dout", {16'd0, data_out}, 32'h27);
      chk_lvl("emp_rw_lvl", 1);

      // Simultaneous at full: read only, overflow, count 7
      for (int i = 0; i < 7; i++) step(0, 1, 0, 16'(16'h50 + i));
      chk_flags("fill_flags", 4'b1000);
      step(0, 1, 1, 16'hDEAD);
      chk_stat("full_rw_stat", 3'b010);
      chk_flags("full_rw_flags", 4'b0100);
      chk("full_rw_dout", {16'd0, data_out}, 32'hAA);
      chk_lvl("full_rw_lvl", 7);

      // Mid-operation reset at count=5
      step(1, 0, 0, 16'h0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 16'(16'h60 + i));
      chk_flags("c5_flags", 4'b0000);
      chk_lvl("c5_lvl", 5);
      step(1, 0, 0, 16'h0);
      chk_flags("mrst_flags", 4'b0001);
      chk("mrst_dout", {16'd0, data_out}, 32'd0);
      chk_lvl("mrst_lvl", 0);
      step(0, 1, 0, 16'h1234);
      chk_flags("post_wr_flags", 4'b0010);
      chk_lvl("post_wr_lvl", 1);
      step(0, 0, 1, 16'h0);
      chk("post_rd_dout", {16'd0, data_out}, 32'h1234);
      chk_flags("post_rd_flags", 4'b0001);
      chk_stat("post_rd_stat", 3'b000);
      chk_lvl("post_rd_lvl", 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
